// File: rtl/refill_arbiter.sv
// Round-robin refill sequencer between the I-cache and D-cache ports.
// Each transaction is one aligned block read after a fixed memory latency.
module refill_arbiter #(
  parameter int WORD_SIZE   = 32,
  parameter int BLOCK_SIZE  = 16,
  parameter int MEM_LATENCY = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_req,
  input  logic [WORD_SIZE-1:0]            i_addr,
  output logic                            i_done,
  input  logic                            d_req,
  input  logic [WORD_SIZE-1:0]            d_addr,
  output logic                            d_done,
  output logic [WORD_SIZE*BLOCK_SIZE-1:0] rdata,
  output logic                            busy,
  output logic                            owner,
  output logic                            mem_rd,
  output logic [WORD_SIZE-1:0]            mem_addr,
  input  logic [WORD_SIZE*BLOCK_SIZE-1:0] mem_block
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [WORD_SIZE-1:0] OFF_MASK = WORD_SIZE'(BLOCK_SIZE - 1);
  localparam logic [7:0]           LAT_LAST = 8'(MEM_LATENCY - 1);

  state_t                            state_q, state_d;
  logic [7:0]                        cnt_q, cnt_d;
  logic                              owner_q, owner_d;
  logic [WORD_SIZE-1:0]              addr_q, addr_d;
  logic [WORD_SIZE*BLOCK_SIZE-1:0]   rdata_q, rdata_d;
  logic                              i_done_q, i_done_d;
  logic                              d_done_q, d_done_d;
  logic                              grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      owner_q  <= 1'b1;
      addr_q   <= '0;
      rdata_q  <= '0;
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      rdata_q  <= rdata_d;
      i_done_q <= i_done_d;
      d_done_q <= d_done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    rdata_d  = rdata_q;
    i_done_d = 1'b0;
    d_done_d = 1'b0;
    grant    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          // On contention the side that did not own the last transaction wins.
          grant   = (i_req && d_req) ? ~owner_q : d_req;
          owner_d = grant;
          addr_d  = (grant ? d_addr : i_addr) & ~OFF_MASK;
          cnt_d   = 8'd0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == LAT_LAST) begin
          rdata_d  = mem_block;
          i_done_d = ~owner_q;
          d_done_d = owner_q;
          state_d  = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign i_done   = i_done_q;
  assign d_done   = d_done_q;
  assign rdata    = rdata_q;
  assign busy     = (state_q != IDLE);
  assign owner    = owner_q;
  assign mem_rd   = (state_q == BUSY);
  assign mem_addr = addr_q;

endmodule

// File: tb/tb_refill_arbiter.sv
// Directed bench for refill_arbiter: cycle table plus multi-cycle corner sequences.
module tb_refill_arbiter;

  logic         clk, rst_n;
  logic         i_req, d_req, i_done, d_done, busy, owner, mem_rd;
  logic [31:0]  i_addr, d_addr, mem_addr;
  logic [511:0] rdata, mem_block;

  logic         i_req1, d_req1, i_done1, d_done1, busy1, owner1, mem_rd1;
  logic [31:0]  i_addr1, d_addr1, mem_addr1;
  logic [511:0] rdata1, mem_block1;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  refill_arbiter #(.WORD_SIZE(32), .BLOCK_SIZE(16), .MEM_LATENCY(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done),
    .d_req(d_req), .d_addr(d_addr), .d_done(d_done),
    .rdata(rdata), .busy(busy), .owner(owner), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .mem_block(mem_block)
  );

  refill_arbiter #(.WORD_SIZE(32), .BLOCK_SIZE(16), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req1), .i_addr(i_addr1), .i_done(i_done1),
    .d_req(d_req1), .d_addr(d_addr1), .d_done(d_done1),
    .rdata(rdata1), .busy(busy1), .owner(owner1), .mem_rd(mem_rd1),
    .mem_addr(mem_addr1), .mem_block(mem_block1)
  );

  // Memory where word n holds the value n; word 0 of a block sits in the MSBs.
  function automatic logic [511:0] blk(input logic [31:0] base);
    logic [511:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[(15-k)*32 +: 32] = base + 32'(k);
    return r;
  endfunction

  always_comb mem_block  = blk(mem_addr);
  always_comb mem_block1 = blk(mem_addr1);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ir, dr;
    logic [31:0] ia, da;
    logic        b, o, idn, ddn, mr;
    logic [31:0] ma;
  } vec_t;

  function automatic vec_t mk(input logic ir, input logic dr, input logic [31:0] ia,
                              input logic [31:0] da, input logic b, input logic o,
                              input logic idn, input logic ddn, input logic mr,
                              input logic [31:0] ma);
    vec_t v;
    v.ir = ir; v.dr = dr; v.ia = ia; v.da = da;
    v.b = b; v.o = o; v.idn = idn; v.ddn = ddn; v.mr = mr; v.ma = ma;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  vec_t tbl[13];
  int   n, seen;
  int   t[4];
  logic g[4];
  logic got, both_err, wide_err, prev_i, prev_d, prev_done1, after_err;

  initial begin
    rst_n = 1'b0;
    i_req = 1'b0; d_req = 1'b0; i_addr = '0; d_addr = '0;
    i_req1 = 1'b0; d_req1 = 1'b0; i_addr1 = '0; d_addr1 = '0;

    tbl[0]  = mk(1'b1, 1'b1, 32'h23, 32'h105, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h20);
    tbl[1]  = mk(1'b1, 1'b1, 32'h23, 32'h105, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h20);
    tbl[2]  = mk(1'b1, 1'b1, 32'h23, 32'h105, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h20);
    tbl[3]  = mk(1'b1, 1'b1, 32'h23, 32'h105, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h20);
    tbl[4]  = mk(1'b1, 1'b1, 32'h23, 32'h105, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h20);
    tbl[5]  = mk(1'b0, 1'b1, 32'h23, 32'h105, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h20);
    tbl[6]  = mk(1'b0, 1'b1, 32'h23, 32'h105, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100);
    tbl[7]  = mk(1'b0, 1'b1, 32'h23, 32'h105, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100);
    tbl[8]  = mk(1'b0, 1'b1, 32'h23, 32'h105, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100);
    tbl[9]  = mk(1'b0, 1'b1, 32'h23, 32'h105, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100);
    tbl[10] = mk(1'b0, 1'b1, 32'h23, 32'h105, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100);
    tbl[11] = mk(1'b0, 1'b0, 32'h23, 32'h105, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100);
    tbl[12] = mk(1'b0, 1'b0, 32'h23, 32'h105, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100);

    // Reset state
    step(); step();
    chk("rst_busy", 512'(busy), 512'd0);
    chk("rst_owner", 512'(owner), 512'd1);
    chk("rst_dones", 512'({i_done, d_done}), 512'd0);
    chk("rst_mem_rd", 512'(mem_rd), 512'd0);
    chk("rst_mem_addr", 512'(mem_addr), 512'd0);
    chk("rst_rdata", rdata, 512'd0);
    rst_n = 1'b1;

    // Contention from reset, then cycle-by-cycle table
    for (int i = 0; i < 13; i++) begin
      i_req = tbl[i].ir; d_req = tbl[i].dr; i_addr = tbl[i].ia; d_addr = tbl[i].da;
      step();
      chk($sformatf("row%0d", i),
          512'({busy, owner, i_done, d_done, mem_rd, mem_addr}),
          512'({tbl[i].b, tbl[i].o, tbl[i].idn, tbl[i].ddn, tbl[i].mr, tbl[i].ma}));
      if (i == 4)  chk("row4_rdata", rdata, blk(32'h20));
      if (i == 10) chk("row10_rdata", rdata, blk(32'h100));
    end

    // Address change during BUSY is ignored
    i_req = 1'b1; i_addr = 32'h40;
    step();
    i_addr = 32'h80;
    got = 1'b0;
    for (int c = 0; c < 12 && !got; c++) begin
      step();
      if (i_done) got = 1'b1;
    end
    chk("addr_done_seen", 512'(got), 512'd1);
    chk("addr_mem_addr", 512'(mem_addr), 512'h40);
    chk("addr_rdata", rdata, blk(32'h40));
    i_req = 1'b0;
    step();

    // Reset asserted in the middle of BUSY
    i_req = 1'b1; i_addr = 32'h60;
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 512'({busy, mem_rd}), 512'd0);
    chk("mid_rst_rdata", rdata, 512'd0);
    i_req = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (c == 2) rst_n = 1'b1;
      if (i_done || d_done) seen++;
    end
    chk("mid_rst_no_done", 512'(seen), 512'd0);
    i_req = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 12 && !got; c++) begin
      step();
      if (i_done) got = 1'b1;
    end
    chk("rereq_done_seen", 512'(got), 512'd1);
    chk("rereq_rdata", rdata, blk(32'h60));
    chk("rereq_owner", 512'(owner), 512'd0);
    i_req = 1'b0;
    step();

    // Both requests held for four transactions after a fresh reset
    rst_n = 1'b0; step(); rst_n = 1'b1;
    i_req = 1'b1; d_req = 1'b1; i_addr = 32'h300; d_addr = 32'h400;
    n = 0; both_err = 1'b0; wide_err = 1'b0; prev_i = 1'b0; prev_d = 1'b0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      step();
      if (i_done && d_done) both_err = 1'b1;
      if ((i_done && prev_i) || (d_done && prev_d)) wide_err = 1'b1;
      if (i_done || d_done) begin
        t[n] = cyc;
        g[n] = d_done;
        n++;
      end
      prev_i = i_done; prev_d = d_done;
    end
    step();
    if (i_done || d_done) wide_err = 1'b1;
    i_req = 1'b0; d_req = 1'b0;
    chk("held_count", 512'(n), 512'd4);
    chk("held_order", 512'({g[0], g[1], g[2], g[3]}), 512'b0101);
    chk("held_overlap", 512'(both_err), 512'd0);
    chk("held_width", 512'(wide_err), 512'd0);
    chk("held_period", 512'({t[1]-t[0], t[2]-t[1], t[3]-t[2]}), 512'({32'd6, 32'd6, 32'd6}));
    step(); step();

    // MEM_LATENCY=1 with d_req held
    d_req1 = 1'b1; d_addr1 = 32'h205;
    n = 0; after_err = 1'b0; prev_done1 = 1'b0;
    for (int c = 0; c < 30 && n < 3; c++) begin
      step();
      if (prev_done1 && busy1) after_err = 1'b1;
      if (d_done1) begin
        t[n] = cyc;
        n++;
      end
      prev_done1 = d_done1;
    end
    step();
    if (prev_done1 && busy1) after_err = 1'b1;
    d_req1 = 1'b0;
    chk("lat1_count", 512'(n), 512'd3);
    chk("lat1_period", 512'({t[1]-t[0], t[2]-t[1]}), 512'({32'd3, 32'd3}));
    chk("lat1_idle_after_done", 512'(after_err), 512'd0);
    chk("lat1_rdata", rdata1, blk(32'h200));
    chk("lat1_no_idone", 512'(i_done1), 512'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/refill_arbiter.md
Name: refill_arbiter

Overview:
- Sequences block refills from the shared block-read instruction/data memory.
- Arbitrates between two requesters: the I-cache (port i_*) and the D-cache (port d_*).
- Models a fixed memory access latency.
- Returns one aligned 16-word block per transaction with a one-cycle done pulse. Sits between the cache controllers and the memory array.

Parameters:
WORD_SIZE, 32, bits per word; also the address width.
BLOCK_SIZE, 16, words per block; fixed at 16, so the offset field is addr[3:0].
MEM_LATENCY, 4, BUSY cycles before the block is sampled; legal range 1..255.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
i_req  input  1  I-cache refill request; level, held until i_done
i_addr  input  WORD_SIZE  I-cache word address; stable while i_req is high
i_done  output  1  one-cycle pulse; rdata holds the I-cache block
d_req  input  1  D-cache refill request; level, held until d_done
d_addr  input  WORD_SIZE  D-cache word address
d_done  output  1  one-cycle pulse; rdata holds the D-cache block
rdata  output  WORD_SIZE*BLOCK_SIZE  captured block; word 0 in the MSBs
busy  output  1  high in the BUSY and RESP states
owner  output  1  0 = I-cache, 1 = D-cache; owner of the current or last transaction
mem_rd  output  1  memory read enable; high in BUSY
mem_addr  output  WORD_SIZE  block-aligned address {addr[WS-1:4], 4'b0}
mem_block  input  WORD_SIZE*BLOCK_SIZE  combinational block read of mem_addr

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, cnt=0.
  - i_done=d_done=0, busy=0, mem_rd=0.
  - mem_addr=0, rdata=0.
  - owner=1 (last_grant=D), so the first contention goes to the I-cache.
- FSM IDLE -> BUSY -> RESP -> IDLE.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requests: grant the requester != owner (round-robin).
  - On grant, at the same edge: latch owner, latch mem_addr with addr[3:0] cleared, cnt=0, go to BUSY.
- BUSY:
  - mem_rd=1.
  - Each edge: cnt <= cnt+1.
  - At the edge where cnt==MEM_LATENCY-1: rdata <= mem_block, assert the owner's done (registered), go to RESP.
- RESP:
  - The done flag is high for exactly this one cycle.
  - Next edge: done=0, go to IDLE.
  - Requests are not sampled in RESP. This masks the still-high req of the finishing requester.
- Latency:
  - Accept edge E. done is high in the cycle after edge E+MEM_LATENCY.
  - Next accept is possible at edge E+MEM_LATENCY+2, giving a per-transaction period of MEM_LATENCY+2 cycles.
- Requester rule: deassert req in the cycle after its done. If req is still high at the next IDLE sample, it is treated as a new request.
- Addresses are latched at accept. Changes to i_addr or d_addr during BUSY are ignored.
- A request arriving during BUSY or RESP waits. It is serviced from IDLE under round-robin.
- rdata holds its value until the next capture. Only the owner's done qualifies it.
- i_done and d_done are never high together. done is never asserted without a prior accept.
- Reset mid-operation: abort immediately. No done pulse is issued. rdata is cleared. The requester must re-request.
- Address wrap: mem_addr truncates to WORD_SIZE bits; no range check.
- cnt is 8 bits wide. MEM_LATENCY=1 gives a single BUSY cycle.

Test Plan:
- Single I-cache refill, MEM_LATENCY=4, i_addr=0x23, memory word n=n:
  - accept edge E; mem_addr=0x20; mem_rd high for 4 cycles.
  - i_done high for one cycle after edge E+4.
  - rdata words = 0x20..0x2F, with word 0x20 in the MSBs.
- Simultaneous i_req and d_req from reset:
  - I-cache served first, then D-cache.
  - owner goes 0 then 1; i_done and d_done are 6 cycles apart.
  - Neither requester is starved.
- Held requests for 4 transactions:
  - grants alternate I, D, I, D.
  - Each done is one cycle wide; done pulses never overlap.
- i_addr changed from 0x40 to 0x80 during BUSY:
  - mem_addr stays 0x40.
  - rdata is the 0x40 block.
- rst_n pulsed low during BUSY:
  - busy, mem_rd and rdata go to 0 asynchronously.
  - No i_done or d_done pulse appears.
  - A re-request after reset completes normally.
- MEM_LATENCY=1, d_req held continuously:
  - d_done pulses every 3 cycles.
  - The request is not re-accepted in the RESP cycle.
